// File: rtl/simple_pkg.sv
// Shared types and constants for the SIMPLE pipeline (decode, memwb, register file).
// Pure declarations, no logic; latency n/a.
// No flow control here; consumers own backpressure.
package simple_pkg;

  localparam int RA_W   = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [1:0] MW_ALU   = 2'b00;
  localparam logic [1:0] MW_LOAD  = 2'b01;
  localparam logic [1:0] MW_STORE = 2'b10;

  typedef enum logic {
    STATE_IDLE,
    STATE_WAIT_ACK
  } state_t;

  // What the write-back side still needs once a memory op is in flight.
  typedef struct packed {
    logic            writereg;
    logic            is_load;
    logic [RA_W-1:0] regaddress;
  } pend_t;

endpackage

// File: rtl/p4_memwb_mem_req_ctrl.sv
// Data-memory request/ack handshake with an ack timeout.
// Request rises the cycle after start; done/abort are combinational in the ack/limit cycle.
// Holds mem_req and its address/data stable until ack or timeout.
module mem_req_ctrl
  import simple_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              abort,
  output logic [DATA_W-1:0] rdata
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Abort fires on the edge where the no-ack count would reach the limit; an ack in that cycle wins.
  assign done  = mem_req && mem_ack;
  assign abort = mem_req && !mem_ack && (wait_cnt == TW'(ACK_TIMEOUT - 1));
  assign rdata = mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= we;
      mem_addr  <= addr;
      mem_wdata <= wdata;
      wait_cnt  <= '0;
    end else if (mem_req) begin
      if (done || abort) begin
        mem_req <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/p4_memwb.sv
// Memory-access / write-back stage: ALU writeback, loads and stores, illegal-op and timeout flags.
// ALU result reaches the register file one cycle after accept; loads write on the ack edge.
// stall is high while a memory op is outstanding; upstream holds its bundle meanwhile.
module p4_memwb
  import simple_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              writereg,
  input  logic [1:0]        memwrite,
  input  logic [RA_W-1:0]   regaddress,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] storedata,
  input  logic [DATA_W-1:0] aluresult,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err_illegal,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  retired
);

  state_t            state, state_nxt;
  pend_t             pend;
  logic              accept;
  logic              start;
  logic              done, abort;
  logic [DATA_W-1:0] rdata;
  logic              retire;
  logic              rf_we_nxt, ill_nxt, to_nxt;
  logic [RA_W-1:0]   rf_addr_nxt;
  logic [DATA_W-1:0] rf_wdata_nxt;

  assign stall  = (state == STATE_WAIT_ACK);
  assign accept = valid_in && (state == STATE_IDLE);

  mem_req_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_mem_req_ctrl (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .we       (memwrite == MW_STORE),
    .addr     (address),
    .wdata    (storedata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .done     (done),
    .abort    (abort),
    .rdata    (rdata)
  );

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    retire       = 1'b0;
    rf_we_nxt    = 1'b0;
    rf_addr_nxt  = rf_addr;
    rf_wdata_nxt = rf_wdata;
    ill_nxt      = 1'b0;
    to_nxt       = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (valid_in) begin
          case (memwrite)
            MW_ALU: begin
              retire = 1'b1;
              if (writereg) begin
                rf_we_nxt    = 1'b1;
                rf_addr_nxt  = regaddress;
                rf_wdata_nxt = aluresult;
              end
            end
            MW_LOAD, MW_STORE: begin
              start     = 1'b1;
              state_nxt = STATE_WAIT_ACK;
            end
            default: ill_nxt = 1'b1;
          endcase
        end
      end
      STATE_WAIT_ACK: begin
        if (done) begin
          state_nxt = STATE_IDLE;
          retire    = 1'b1;
          // Stores never write the register file, whatever writereg says.
          if (pend.writereg && pend.is_load) begin
            rf_we_nxt    = 1'b1;
            rf_addr_nxt  = pend.regaddress;
            rf_wdata_nxt = rdata;
          end
        end else if (abort) begin
          state_nxt = STATE_IDLE;
          to_nxt    = 1'b1;
        end
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= STATE_IDLE;
      pend        <= '0;
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      rf_we       <= rf_we_nxt;
      rf_addr     <= rf_addr_nxt;
      rf_wdata    <= rf_wdata_nxt;
      err_illegal <= ill_nxt;
      err_timeout <= to_nxt;
      if (accept) begin
        pend <= '{writereg: writereg, is_load: (memwrite == MW_LOAD), regaddress: regaddress};
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_p4_memwb.sv
// Directed bench for p4_memwb with a transaction-level reference model checked every cycle.
module tb_p4_memwb;

  localparam int T = 4;

  logic        clock, reset;
  logic        valid_in, writereg;
  logic [1:0]  memwrite;
  logic [2:0]  regaddress;
  logic [15:0] address, storedata, aluresult;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic        err_illegal, err_timeout;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  p4_memwb #(.ACK_TIMEOUT(T), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .writereg(writereg),
    .memwrite(memwrite), .regaddress(regaddress), .address(address),
    .storedata(storedata), .aluresult(aluresult), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight memory op at most, tracked as a transaction.
  logic        m_live = 0, m_busy = 0, m_load = 0, m_wr = 0;
  logic [2:0]  m_dest = 0;
  int          m_waits = 0;
  logic        e_req = 0, e_we = 0, e_rf_we = 0, e_ill = 0, e_to = 0;
  logic [15:0] e_addr = 0, e_wdata = 0, e_rf_wdata = 0, e_ret = 0;
  logic [2:0]  e_rf_addr = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1; m_busy = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_rf_we = 0; e_rf_addr = 0; e_rf_wdata = 0; e_ill = 0; e_to = 0; e_ret = 0;
    end else begin
      e_rf_we = 0; e_ill = 0; e_to = 0;
      if (!m_busy) begin
        if (valid_in) begin
          case (memwrite)
            2'b00: begin
              e_ret = e_ret + 16'd1;
              if (writereg) begin
                e_rf_we = 1; e_rf_addr = regaddress; e_rf_wdata = aluresult;
              end
            end
            2'b01, 2'b10: begin
              m_busy = 1; m_waits = 0; m_load = (memwrite == 2'b01);
              m_wr = writereg; m_dest = regaddress;
              e_req = 1; e_we = (memwrite == 2'b10); e_addr = address; e_wdata = storedata;
            end
            default: e_ill = 1;
          endcase
        end
      end else if (mem_ack) begin
        m_busy = 0; e_req = 0; e_ret = e_ret + 16'd1;
        if (m_load && m_wr) begin
          e_rf_we = 1; e_rf_addr = m_dest; e_rf_wdata = mem_rdata;
        end
      end else begin
        m_waits++;
        if (m_waits == T) begin
          m_busy = 0; e_req = 0; e_to = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("m_stall", stall, m_busy);
      chk("m_req", mem_req, e_req);
      chk("m_rf_we", rf_we, e_rf_we);
      chk("m_rf_addr", rf_addr, e_rf_addr);
      chk("m_rf_wdata", rf_wdata, e_rf_wdata);
      chk("m_ill", err_illegal, e_ill);
      chk("m_to", err_timeout, e_to);
      chk("m_retired", retired, e_ret);
      if (e_req) begin
        chk("m_we", mem_we, e_we);
        chk("m_addr", mem_addr, e_addr);
        chk("m_wdata", mem_wdata, e_wdata);
      end
    end
  end

  int req_cnt = 0, rfwe_cnt = 0, to_cnt = 0, ill_cnt = 0;
  always @(negedge clock) begin
    if (mem_req)     req_cnt++;
    if (rf_we)       rfwe_cnt++;
    if (err_timeout) to_cnt++;
    if (err_illegal) ill_cnt++;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clr();
    req_cnt = 0; rfwe_cnt = 0; to_cnt = 0; ill_cnt = 0;
  endtask

  task automatic drive(input logic [1:0] mw, input logic wr, input logic [2:0] ra,
                       input logic [15:0] ad, input logic [15:0] sd, input logic [15:0] alu);
    valid_in = 1; memwrite = mw; writereg = wr; regaddress = ra;
    address = ad; storedata = sd; aluresult = alu;
  endtask

  initial begin
    reset = 1; valid_in = 0; writereg = 0; memwrite = 0; regaddress = 0;
    address = 0; storedata = 0; aluresult = 0; mem_rdata = 0; mem_ack = 0;
    step(); step();
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", {err_illegal, err_timeout}, 0);
    reset = 0;

    // ALU writeback
    drive(2'b00, 1, 3'd5, 16'h0, 16'h0, 16'h1234);
    step();
    valid_in = 0; aluresult = 16'hDEAD;
    chk("alu_rf_we", rf_we, 1);
    chk("alu_rf_addr", rf_addr, 5);
    chk("alu_rf_wdata", rf_wdata, 16'h1234);
    chk("alu_stall", stall, 0);
    chk("alu_retired", retired, 1);

    // Load, ack in third request cycle, next bundle waiting behind it
    clr();
    drive(2'b01, 1, 3'd2, 16'h0040, 16'h0, 16'h0);
    step();
    valid_in = 0; address = 16'hFFFF; regaddress = 3'd7;
    chk("ld_stall", stall, 1);
    chk("ld_we", mem_we, 0);
    chk("ld_addr", mem_addr, 16'h0040);
    step();
    chk("ld_stall2", stall, 1);
    step();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    drive(2'b00, 1, 3'd3, 16'h0, 16'h0, 16'h0033);
    step();
    mem_ack = 0; mem_rdata = 16'h0;
    chk("ld_rf_we", rf_we, 1);
    chk("ld_rf_addr", rf_addr, 2);
    chk("ld_rf_wdata", rf_wdata, 16'hBEEF);
    chk("ld_req_cycles", req_cnt, 3);
    chk("ld_retired", retired, 2);
    step();
    valid_in = 0;
    chk("nx_rf_addr", rf_addr, 3);
    chk("nx_rf_wdata", rf_wdata, 16'h0033);
    chk("nx_retired", retired, 3);

    // Store with writereg set
    clr();
    drive(2'b10, 1, 3'd6, 16'h00FF, 16'hA5A5, 16'h0);
    step();
    valid_in = 0; storedata = 16'h0;
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 16'h00FF);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("st_rf_we", rfwe_cnt, 0);
    chk("st_retired", retired, 4);
    chk("st_stall", stall, 0);

    // Load timeout
    clr();
    drive(2'b01, 1, 3'd1, 16'h0010, 16'h0, 16'h0);
    step();
    valid_in = 0;
    repeat (6) step();
    chk("to_req_cycles", req_cnt, T);
    chk("to_pulses", to_cnt, 1);
    chk("to_rf_we", rfwe_cnt, 0);
    chk("to_retired", retired, 4);
    chk("to_stall", stall, 0);

    // Reset during a load, late ack must be ignored
    clr();
    drive(2'b01, 1, 3'd4, 16'h0020, 16'h0, 16'h0);
    step();
    valid_in = 0;
    step();
    reset = 1;
    step();
    reset = 0; mem_ack = 1; mem_rdata = 16'h1111;
    chk("rs_req", mem_req, 0);
    chk("rs_stall", stall, 0);
    chk("rs_retired", retired, 0);
    chk("rs_rf_addr", rf_addr, 0);
    step();
    mem_ack = 0;
    chk("rs_rf_we", rfwe_cnt, 0);
    chk("rs_retired2", retired, 0);
    chk("rs_req2", mem_req, 0);

    // Illegal then three back-to-back ALU ops
    clr();
    drive(2'b11, 1, 3'd7, 16'h0, 16'h0, 16'h7777);
    step();
    chk("il_pulse", err_illegal, 1);
    chk("il_rf_we", rf_we, 0);
    drive(2'b00, 1, 3'd1, 16'h0, 16'h0, 16'h0101);
    step();
    chk("b1_addr", {rf_we, rf_addr}, {1'b1, 3'd1});
    drive(2'b00, 1, 3'd2, 16'h0, 16'h0, 16'h0202);
    step();
    chk("b2_addr", {rf_we, rf_addr}, {1'b1, 3'd2});
    drive(2'b00, 1, 3'd0, 16'h0, 16'h0, 16'h0303);
    step();
    valid_in = 0;
    chk("b3_addr", {rf_we, rf_addr}, {1'b1, 3'd0});
    chk("b3_wdata", rf_wdata, 16'h0303);
    step();
    chk("il_count", ill_cnt, 1);
    chk("bb_rf_count", rfwe_cnt, 3);
    chk("bb_retired", retired, 3);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p4_memwb.md
Name: p4_memwb

Overview:
- Memory-access / write-back stage of the SIMPLE pipeline.
- Consumes the decoded control bundle produced by the decode stage: writereg, memwrite, regaddress, address, storedata, plus the ALU result from execute.
- Performs loads and stores over a request/acknowledge data-memory interface and drives the register-file write port, so it closes the read→execute→write loop on the register file.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 16, max cycles to wait for mem_ack before aborting the transaction.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  pipeline clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream bundle valid this cycle.
- writereg  in  1  instruction writes a register.
- memwrite  in  2  00 ALU writeback, 01 load, 10 store, 11 illegal.
- regaddress  in  3  destination register.
- address  in  16  memory address.
- storedata  in  16  store data.
- aluresult  in  16  execute-stage result.
- stall  out  1  high while busy; upstream holds its bundle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_addr  out  3  register-file write address.
- rf_wdata  out  16  register-file write data.
- err_illegal  out  1  one-cycle pulse when memwrite==11 is accepted.
- err_timeout  out  1  one-cycle pulse when a transaction is aborted.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: every output is 0 and state = IDLE. Reset asserted mid-transaction drops mem_req at that edge, discards the pending instruction, writes nothing to the register file and does not change retired.
- State machine: IDLE, WAIT_ACK.
- stall = (state == WAIT_ACK), combinational from state.
- Accept occurs when valid_in && state == IDLE. All input fields are latched at the accept edge, so later input changes have no effect.
- memwrite 00, accepted at edge N:
  - If writereg: at N+1, rf_we=1, rf_addr=regaddress, rf_wdata=aluresult.
  - retired increments at N+1 whether or not writereg is set.
  - Stays in IDLE; back-to-back ALU ops at one per cycle.
- memwrite 01 (load):
  - Go to WAIT_ACK. From N+1, mem_req=1, mem_we=0, mem_addr=address.
  - On the edge where mem_req && mem_ack, capture mem_rdata, drop mem_req, return to IDLE. At that same edge, if writereg, rf_we=1 with rf_addr/rf_wdata = latched dest/rdata.
  - retired increments at that edge.
  - Earliest completion: ack in cycle N+1 gives the write at N+2.
- memwrite 10 (store):
  - WAIT_ACK with mem_req=1, mem_we=1, mem_addr=address, mem_wdata=storedata.
  - On ack, return to IDLE and increment retired. No rf write, even if writereg is set.
- memwrite 11: no memory or register action. err_illegal pulses at N+1; retired is not incremented.
- mem_ack while mem_req==0 is ignored.
- mem_addr, mem_we and mem_wdata are held stable for the whole request.
- Timeout:
  - The counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack.
  - When it reaches ACK_TIMEOUT, at that edge drop mem_req, return to IDLE and pulse err_timeout. No rf write; retired is unchanged.
  - If ack arrives in the same cycle as the limit, ack wins and the transaction completes normally.
- rf_we, err_illegal and err_timeout are single-cycle pulses, 0 otherwise. rf_addr and rf_wdata hold their last value when rf_we=0.
- Register 0 is writable (no hard-wired zero).
- retired wraps modulo 2^CNT_W.

Decomposition:
- Shared package `simple_pkg`:
  - memwrite encodings MW_ALU=2'b00, MW_LOAD=2'b01, MW_STORE=2'b10.
  - State enum STATE_IDLE / STATE_WAIT_ACK.
  - Register-address width 3 and data width 16 constants, shared with the decode stage and the register file.
- One sub-module is natural: `mem_req_ctrl`, which owns the request/ack handshake and the timeout counter, and returns done/abort/rdata.

Test Plan:
- ALU writeback: accept {memwrite=00, writereg=1, regaddress=5, aluresult=16'h1234} at edge N → at N+1 rf_we=1, rf_addr=5, rf_wdata=1234, stall=0, retired=1.
- Load with 3-cycle ack: address=16'h0040, regaddress=2, mem_rdata=16'hBEEF with ack in the third request cycle → mem_req high 3 cycles, mem_we=0, mem_addr=0040, stall high throughout; rf_we=1 with r2=BEEF on the ack edge; the next bundle is accepted the following cycle.
- Store with writereg=1: address=16'h00FF, storedata=16'hA5A5, ack after 1 cycle → mem_we=1, mem_wdata=A5A5; rf_we stays 0; retired increments.
- Timeout with ACK_TIMEOUT=4: load, no ack → mem_req high exactly 4 cycles, err_timeout pulses once, no rf_we, retired unchanged, stall falls.
- Reset mid-load: assert reset in the second WAIT_ACK cycle, then ack one cycle later → mem_req=0 after reset edge, no rf_we, retired=0, state IDLE.
- Illegal plus back-to-back ALU ops: memwrite=11, then three consecutive ALU ops → one err_illegal pulse, then three rf_we pulses on consecutive cycles, retired=3.
